// File: rtl/maheredia_player_input.sv
// Two-channel player button front end: sync, debounce, press detect, req/ack handshake.
// Optional sticky early-press flags enabled by defining PLAYER_INPUT_FOUL_EN.
module maheredia_player_input #(
  parameter int unsigned CLOCK_FREQ  = 1000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       player_1_in_n,
  input  logic       player_2_in_n,
  input  logic       arm_in,
  input  logic       ack1_in,
  input  logic       ack2_in,
  input  logic       foul_clr_in,
  output logic       req1_out,
  output logic       req2_out,
  output logic [1:0] pressed_out,
  output logic       foul1_out,
  output logic       foul2_out
);

  localparam int unsigned DEBOUNCE_RAW   = CLOCK_FREQ * DEBOUNCE_MS / 1000;
  localparam int unsigned DEBOUNCE_COUNT = (DEBOUNCE_RAW < 1) ? 1 : DEBOUNCE_RAW;
  localparam int unsigned CNT_W          = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  logic [1:0] pin_n;
  logic [1:0] ack;
  logic [1:0] req_all;
  logic [1:0] stable_all;
  logic [1:0] foul_all;

  assign pin_n = {player_2_in_n, player_1_in_n};
  assign ack   = {ack2_in, ack1_in};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             sync1_q;
    logic             raw_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             press_c;
    logic             release_c;
    logic             foul_set_c;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q       <= 1'b0;
        raw_s_q       <= 1'b0;
        cnt_q         <= '0;
        stable_q      <= 1'b0;
        stable_prev_q <= 1'b0;
        state_q       <= IDLE;
        req_q         <= 1'b0;
      end else begin
        sync1_q       <= ~pin_n[g];
        raw_s_q       <= sync1_q;
        cnt_q         <= cnt_d;
        stable_q      <= stable_d;
        stable_prev_q <= stable_q;
        state_q       <= state_d;
        req_q         <= req_d;
      end
    end

    // Debounce: accept raw level only after it differs from stable for DEBOUNCE_COUNT cycles.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (raw_s_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = raw_s_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign press_c   = stable_q & ~stable_prev_q;
    assign release_c = ~stable_q & stable_prev_q;

    always_comb begin
      state_d    = state_q;
      foul_set_c = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press_c) begin
            if (arm_in) begin
              state_d = REQ;
            end else begin
              state_d    = LOCK;
              foul_set_c = 1'b1;
            end
          end
        end
        REQ: begin
          if (ack[g] || !arm_in) state_d = LOCK;
        end
        LOCK: begin
          if (release_c) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      req_d = (state_d == REQ);
    end

`ifdef PLAYER_INPUT_FOUL_EN
    logic foul_q, foul_d;

    // Set wins over a same-cycle clear.
    assign foul_d = foul_set_c | (foul_q & ~foul_clr_in);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) foul_q <= 1'b0;
      else       foul_q <= foul_d;
    end

    assign foul_all[g] = foul_q;
`else
    logic unused_foul_set;
    assign unused_foul_set = foul_set_c;
    assign foul_all[g]     = 1'b0;
`endif

    assign req_all[g]    = req_q;
    assign stable_all[g] = stable_q;
  end

`ifndef PLAYER_INPUT_FOUL_EN
  logic unused_foul_clr;
  assign unused_foul_clr = foul_clr_in;
`endif

  assign req1_out    = req_all[0];
  assign req2_out    = req_all[1];
  assign pressed_out = stable_all;
  assign foul1_out   = foul_all[0];
  assign foul2_out   = foul_all[1];

endmodule

// File: tb/tb_maheredia_player_input.sv
// Directed bench for maheredia_player_input: debounce latency, handshake, lockout, reset, fouls.
module tb_maheredia_player_input;

`ifdef PLAYER_INPUT_FOUL_EN
  localparam logic FOUL_EXP = 1'b1;
`else
  localparam logic FOUL_EXP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       p1_n, p2_n, arm, ack1, ack2, clr;
  logic       req1, req2, foul1, foul2;
  logic [1:0] pressed;

  logic       q1_n, q2_n, arm0, ack0;
  logic       r1b, r2b, f1b, f2b;
  logic [1:0] pressed_b;

  int n_total = 0;
  int n_pass  = 0;

  maheredia_player_input #(.CLOCK_FREQ(1000), .DEBOUNCE_MS(4)) dut (
    .clk(clk), .reset(reset),
    .player_1_in_n(p1_n), .player_2_in_n(p2_n),
    .arm_in(arm), .ack1_in(ack1), .ack2_in(ack2), .foul_clr_in(clr),
    .req1_out(req1), .req2_out(req2), .pressed_out(pressed),
    .foul1_out(foul1), .foul2_out(foul2)
  );

  maheredia_player_input #(.CLOCK_FREQ(1000), .DEBOUNCE_MS(0)) dut0 (
    .clk(clk), .reset(reset),
    .player_1_in_n(q1_n), .player_2_in_n(q2_n),
    .arm_in(arm0), .ack1_in(ack0), .ack2_in(ack0), .foul_clr_in(ack0),
    .req1_out(r1b), .req2_out(r2b), .pressed_out(pressed_b),
    .foul1_out(f1b), .foul2_out(f2b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    p1_n = 1'b1; p2_n = 1'b1; arm = 1'b0; ack1 = 1'b0; ack2 = 1'b0; clr = 1'b0;
    q1_n = 1'b1; q2_n = 1'b1; arm0 = 1'b1; ack0 = 1'b0;
    tick(2);
    check("rst_req", {6'd0, req2, req1}, 8'h00);
    reset = 1'b0;
    tick(3);
    check("idle_req", {6'd0, req2, req1}, 8'h00);
    check("idle_pressed", {6'd0, pressed}, 8'h00);
    check("idle_foul", {6'd0, foul2, foul1}, 8'h00);

    // Clean press with window open
    arm = 1'b1; p1_n = 1'b0;
    tick(6);
    check("p1_edge6_req", {7'd0, req1}, 8'h00);
    check("p1_edge6_pressed", {6'd0, pressed}, 8'h01);
    tick(1);
    check("p1_edge7_req", {7'd0, req1}, 8'h01);
    ack1 = 1'b1;
    tick(1);
    ack1 = 1'b0;
    check("p1_ack_drop", {7'd0, req1}, 8'h00);
    tick(10);
    check("p1_held_no_rereq", {7'd0, req1}, 8'h00);
    p1_n = 1'b1;
    tick(8);
    check("p1_release", {6'd0, pressed}, 8'h00);
    p1_n = 1'b0;
    tick(7);
    check("p1_repress_req", {7'd0, req1}, 8'h01);
    ack1 = 1'b1; tick(1); ack1 = 1'b0;
    p1_n = 1'b1;
    tick(8);

    // Bouncing input: six 3-cycle segments, then held low
    for (int i = 0; i < 6; i++) begin
      p1_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
      check("bounce_no_req", {7'd0, req1}, 8'h00);
    end
    p1_n = 1'b0;
    tick(6);
    check("bounce_edge6", {7'd0, req1}, 8'h00);
    tick(1);
    check("bounce_edge7", {7'd0, req1}, 8'h01);
    ack1 = 1'b1; tick(1); ack1 = 1'b0;
    p1_n = 1'b1;
    tick(8);

    // Early press on player 2
    arm = 1'b0; p2_n = 1'b0;
    tick(8);
    check("early_req2", {7'd0, req2}, 8'h00);
    check("early_foul2", {7'd0, foul2}, {7'd0, FOUL_EXP});
    check("early_foul1", {7'd0, foul1}, 8'h00);
    check("early_pressed", {6'd0, pressed}, 8'h02);
    arm = 1'b1;
    tick(3);
    check("early_arm_held", {7'd0, req2}, 8'h00);
    p2_n = 1'b1;
    tick(8);
    p2_n = 1'b0;
    tick(7);
    check("early_repress_req2", {7'd0, req2}, 8'h01);
    check("foul2_sticky", {7'd0, foul2}, {7'd0, FOUL_EXP});
    clr = 1'b1; tick(1); clr = 1'b0;
    check("foul2_cleared", {7'd0, foul2}, 8'h00);
    ack2 = 1'b1; tick(1); ack2 = 1'b0;
    p2_n = 1'b1;
    tick(8);

    // Simultaneous presses
    p1_n = 1'b0; p2_n = 1'b0;
    tick(6);
    check("both_edge6", {6'd0, req2, req1}, 8'h00);
    tick(1);
    check("both_edge7", {6'd0, req2, req1}, 8'h03);
    check("both_pressed", {6'd0, pressed}, 8'h03);
    ack2 = 1'b1; tick(1); ack2 = 1'b0;
    check("ack2_only", {6'd0, req2, req1}, 8'h01);

    // Disarm drops the pending request
    arm = 1'b0;
    tick(1);
    check("disarm_drop", {7'd0, req1}, 8'h00);
    p1_n = 1'b1; p2_n = 1'b1;
    tick(8);
    arm = 1'b1; p1_n = 1'b0;
    tick(7);
    check("pre_reset_req1", {7'd0, req1}, 8'h01);

    // Async reset mid-request, then button still held at release
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", {6'd0, req2, req1}, 8'h00);
    check("async_rst_pressed", {6'd0, pressed}, 8'h00);
    check("async_rst_foul", {6'd0, foul2, foul1}, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("post_rst_edge6", {7'd0, req1}, 8'h00);
    tick(1);
    check("post_rst_edge7", {7'd0, req1}, 8'h01);
    ack1 = 1'b1; tick(1); ack1 = 1'b0;
    p1_n = 1'b1;
    tick(8);

    // Zero debounce time forces a count of one
    q1_n = 1'b0;
    tick(3);
    check("db0_edge3", {7'd0, r1b}, 8'h00);
    tick(1);
    check("db0_edge4", {7'd0, r1b}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
